// File: rtl/product_acc_pkg.sv
// Shared types and defaults for the product accumulator.
// Build option: PRODUCT_ACC_SAT_EN selects saturating accumulation.
package product_acc_pkg;

  localparam int PROD_W_DEF   = 10;
  localparam int ACC_W_DEF    = 12;
  localparam int NUM_PROD_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/rise_detect.sv
// Registered 0->1 detector for level-style completion signals.
// RST_VAL=1 keeps a level already high at reset release from counting.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_d;

  always_ff @(posedge clk) begin
    if (rst) level_d <= RST_VAL;
    else     level_d <= level;
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/product_accumulator.sv
// Sums NUM_PROD multiplier products per burst, hands result out on valid/ready.
// Build option: PRODUCT_ACC_SAT_EN clamps on overflow, otherwise wraps.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int PROD_W   = PROD_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int NUM_PROD = NUM_PROD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_on,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              busy,
  output logic              ovf,
  output logic              drop_err
);

  localparam int CNT_W = $clog2(NUM_PROD + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PROD - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             hit;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] acc_nxt;

  rise_detect #(
    .RST_VAL(1'b1)
  ) u_rise (
    .clk  (clk),
    .rst  (rst),
    .level(prod_on),
    .rise (hit)
  );

  assign sum   = {1'b0, acc} + (ACC_W + 1)'(prod_in);
  assign carry = sum[ACC_W];

`ifdef PRODUCT_ACC_SAT_EN
  // Once clamped, any further product carries again, so acc stays at max.
  assign acc_nxt = carry ? ACC_MAX : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  assign acc_out = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      drop_err  <= 1'b0;
      acc_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            busy     <= 1'b1;
            acc      <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            drop_err <= 1'b0;
          end
        end
        ACCUM: begin
          // start wins over a coincident product edge
          if (start) begin
            acc      <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            drop_err <= 1'b0;
          end else if (hit) begin
            acc   <= acc_nxt;
            count <= count + 1'b1;
            if (carry) ovf <= 1'b1;
            if (count == LAST) begin
              state     <= HOLD;
              acc_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (hit) drop_err <= 1'b1;
          if (acc_ready) begin
            state     <= IDLE;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          acc_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized self-checking bench for product_accumulator.
// Honours PRODUCT_ACC_SAT_EN to pick the expected overflow behaviour.
module tb_product_accumulator;

  localparam int PW = 10;
  localparam int AW = 12;
  localparam int NP = 8;
  localparam int MAXV = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [PW-1:0] prod_in;
  logic          prod_on;
  logic [AW-1:0] acc_out;
  logic          acc_valid;
  logic          acc_ready;
  logic          busy;
  logic          ovf;
  logic          drop_err;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned tot;
  logic [AW-1:0] exp_acc;

  always #5 clk = ~clk;

  product_accumulator #(
    .PROD_W(PW), .ACC_W(AW), .NUM_PROD(NP)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .prod_in(prod_in), .prod_on(prod_on),
    .acc_out(acc_out), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .busy(busy),
    .ovf(ovf), .drop_err(drop_err)
  );

  // Ideal burst result from the running integer total of accepted products.
  function automatic logic [AW-1:0] model(input int unsigned t);
`ifdef PRODUCT_ACC_SAT_EN
    return (t > MAXV) ? AW'(MAXV) : AW'(t);
`else
    return AW'(t % (MAXV + 1));
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_rise(input logic [PW-1:0] v);
    prod_in = v;
    prod_on = 1'b1;
    tick();
    prod_on = 1'b0;
  endtask

  task automatic send(input logic [PW-1:0] v);
    send_rise(v);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; prod_on = 1'b1;
    prod_in = '0; acc_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if ({acc_out, acc_valid, busy, ovf, drop_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got acc=%0d v=%b b=%b o=%b d=%b want all 0",
               acc_out, acc_valid, busy, ovf, drop_err);
    end
    rst = 1'b0;
    pulse_start();
    tick();
    n_checks++;
    if (acc_out !== '0 || busy !== 1'b1 || acc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held_on: got acc=%0d b=%b v=%b want 0 1 0",
               acc_out, busy, acc_valid);
    end
  endtask

  task automatic test_basic();
    acc_ready = 1'b1;
    prod_on = 1'b0;
    tick();
    pulse_start();
    for (int i = 0; i < NP - 1; i++) send(10'd3);
    n_checks++;
    if (acc_valid !== 1'b0 || acc_out !== AW'(21)) begin
      n_fail++;
      $display("FAIL basic_partial: got v=%b acc=%0d want 0 21",
               acc_valid, acc_out);
    end
    send_rise(10'd3);
    n_checks++;
    if (acc_valid !== 1'b1 || acc_out !== AW'(24) || ovf !== 1'b0
        || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done: got v=%b acc=%0d o=%b b=%b want 1 24 0 1",
               acc_valid, acc_out, ovf, busy);
    end
    tick();
    n_checks++;
    if (acc_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_handoff: got v=%b b=%b want 0 0",
               acc_valid, busy);
    end
  endtask

  task automatic test_overflow();
    acc_ready = 1'b0;
    pulse_start();
    tot = 0;
    for (int i = 1; i <= NP; i++) begin
      send_rise(10'd961);
      tot += 961;
      exp_acc = model(tot);
      n_checks++;
      if (acc_out !== exp_acc || ovf !== (tot > MAXV)
          || acc_valid !== (i == NP)) begin
        n_fail++;
        $display("FAIL ovf_step%0d: got acc=%0d o=%b v=%b want %0d %b %b",
                 i, acc_out, ovf, acc_valid, exp_acc, tot > MAXV, i == NP);
      end
      tick();
    end
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    n_checks++;
    if (acc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_handoff: got v=%b want 0", acc_valid);
    end
  endtask

  task automatic test_backpressure();
    acc_ready = 1'b0;
    pulse_start();
    n_checks++;
    if (ovf !== 1'b0 || drop_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_start_clr: got o=%b d=%b want 0 0", ovf, drop_err);
    end
    tot = 0;
    for (int i = 0; i < NP; i++) begin
      prod_in = PW'($urandom_range(0, 400));
      tot += prod_in;
      send(prod_in);
    end
    exp_acc = model(tot);
    n_checks++;
    if (drop_err !== 1'b0 || acc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_enter: got d=%b v=%b want 0 1", drop_err, acc_valid);
    end
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin
          prod_in = PW'($urandom_range(1, 1023));
          prod_on = 1'b1;
        end
        1: prod_on = 1'b0;
        2: start = 1'b1;
        default: start = 1'b0;
      endcase
      tick();
      start = 1'b0;
      n_checks++;
      if (acc_valid !== 1'b1 || acc_out !== exp_acc || busy !== 1'b1
          || drop_err !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b acc=%0d b=%b d=%b want 1 %0d 1 1",
                 k, acc_valid, acc_out, busy, drop_err, exp_acc);
      end
    end
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    n_checks++;
    if (acc_valid !== 1'b0 || busy !== 1'b0 || drop_err !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b b=%b d=%b want 0 0 1",
               acc_valid, busy, drop_err);
    end
  endtask

  task automatic test_restart();
    acc_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 3; i++) send(10'd10);
    n_checks++;
    if (acc_out !== AW'(30)) begin
      n_fail++;
      $display("FAIL restart_pre: got acc=%0d want 30", acc_out);
    end
    prod_in = 10'd10;
    prod_on = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    prod_on = 1'b0;
    n_checks++;
    if (acc_out !== '0 || busy !== 1'b1 || drop_err !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clr: got acc=%0d b=%b d=%b want 0 1 0",
               acc_out, busy, drop_err);
    end
    tick();
    for (int i = 0; i < NP - 1; i++) send(10'd1);
    n_checks++;
    if (acc_valid !== 1'b0 || acc_out !== AW'(7)) begin
      n_fail++;
      $display("FAIL restart_cnt: got v=%b acc=%0d want 0 7",
               acc_valid, acc_out);
    end
    send_rise(10'd1);
    n_checks++;
    if (acc_valid !== 1'b1 || acc_out !== AW'(8)) begin
      n_fail++;
      $display("FAIL restart_done: got v=%b acc=%0d want 1 8",
               acc_valid, acc_out);
    end
    tick();
  endtask

  task automatic test_random();
    for (int b = 0; b < 4; b++) begin
      acc_ready = 1'b0;
      pulse_start();
      tot = 0;
      for (int i = 0; i < NP; i++) begin
        prod_in = PW'($urandom_range(0, 1023));
        tot += prod_in;
        send(prod_in);
        repeat ($urandom_range(0, 2)) tick();
      end
      exp_acc = model(tot);
      repeat ($urandom_range(0, 3)) tick();
      n_checks++;
      if (acc_valid !== 1'b1 || acc_out !== exp_acc
          || ovf !== (tot > MAXV)) begin
        n_fail++;
        $display("FAIL rand_b%0d: got v=%b acc=%0d o=%b want 1 %0d %b",
                 b, acc_valid, acc_out, ovf, exp_acc, tot > MAXV);
      end
      acc_ready = 1'b1;
      tick();
      n_checks++;
      if (acc_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_hand%0d: got v=%b want 0", b, acc_valid);
      end
    end
    acc_ready = 1'b0;
  endtask

  task automatic test_reset_midburst();
    acc_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) send(10'd100);
    n_checks++;
    if (acc_out !== AW'(400)) begin
      n_fail++;
      $display("FAIL mid_pre: got acc=%0d want 400", acc_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (acc_out !== '0 || acc_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: got acc=%0d v=%b b=%b want 0 0 0",
               acc_out, acc_valid, busy);
    end
    for (int i = 0; i < 10; i++) begin
      send(10'd100);
      n_checks++;
      if (acc_valid !== 1'b0 || acc_out !== '0) begin
        n_fail++;
        $display("FAIL mid_idle%0d: got v=%b acc=%0d want 0 0",
                 i, acc_valid, acc_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_restart();
    test_random();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
